keypad_scanner: RTL and testbench

Matrix-keypad front end for the calculator: scans a 4x4 active-low keypad, synchronises and debounces the row lines, and emits one raw key code per physical press. It sits directly upstream of the operand/operator storage registers. `key_valid` is a single-cycle strobe that loads or enables those registers. `key_held` is a level suitable for a 1-bit state register.

---
 rtl/calc_pkg.sv | 46 ++++
 rtl/keypad_scanner_if.sv | 24 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/keypad_scanner.sv | 106 ++++++++++
 tb/tb_keypad_scanner.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator types: scanner states, column drives, raw key codes
package calc_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESS    = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] COL0_N = 4'b1110;
    localparam logic [3:0] COL1_N = 4'b1101;
    localparam logic [3:0] COL2_N = 4'b1011;
    localparam logic [3:0] COL3_N = 4'b0111;

    // Raw code = row*4 + col for the usual 1-2-3-A / 4-5-6-B / 7-8-9-C / *-0-#-D layout.
    typedef enum logic [3:0] {
        KEY_1    = 4'd0,  KEY_2 = 4'd1,  KEY_3    = 4'd2,  KEY_A = 4'd3,
        KEY_4    = 4'd4,  KEY_5 = 4'd5,  KEY_6    = 4'd6,  KEY_B = 4'd7,
        KEY_7    = 4'd8,  KEY_8 = 4'd9,  KEY_9    = 4'd10, KEY_C = 4'd11,
        KEY_STAR = 4'd12, KEY_0 = 4'd13, KEY_HASH = 4'd14, KEY_D = 4'd15
    } key_code_t;

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drive;
        drive = COL0_N;
        case (idx)
            2'd0: drive = COL0_N;
            2'd1: drive = COL1_N;
            2'd2: drive = COL2_N;
            2'd3: drive = COL3_N;
        endcase
        return drive;
    endfunction

    // Lowest-numbered low row wins when several rows are pulled down at once.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix lines and key event outputs
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-parameterised two-flop synchroniser, resets to all ones
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // Two back-to-back flops; reset value reads as "all lines released".
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, debounce and key event generation
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    keypad_scanner_if.master    kp
);
    localparam int CNT_TOP = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_TOP);

    scan_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       col_idx;
    logic [1:0]       col_next;
    logic [3:0]       rows_lat;
    logic [3:0]       rows_s;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.row_in),
        .q     (rows_s)
    );

    // One shared counter serves dwell, press debounce and release debounce; it saturates.
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign col_next = col_idx + 2'd1;

    // Scan/debounce FSM with registered column drive and key outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_SCAN;
            cnt          <= '0;
            col_idx      <= 2'd0;
            rows_lat     <= 4'hF;
            kp.col_out   <= COL0_N;
            kp.key_code  <= 4'd0;
            kp.key_valid <= 1'b0;
            kp.key_held  <= 1'b0;
        end else begin
            kp.key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rows_s != 4'hF) begin
                            rows_lat <= rows_s;
                            state    <= ST_DEBOUNCE;
                        end else begin
                            col_idx    <= col_next;
                            kp.col_out <= col_drive(col_next);
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rows_s == rows_lat) begin
                        if (cnt == DEB_LAST) begin
                            cnt   <= '0;
                            state <= ST_PRESS;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        // Bounce or early release: resume scanning this same column.
                        cnt   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_PRESS: begin
                    kp.key_valid <= 1'b1;
                    kp.key_code  <= {lowest_low_row(rows_lat), col_idx};
                    kp.key_held  <= 1'b1;
                    cnt          <= '0;
                    state        <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (rows_s == 4'hF) begin
                        if (cnt == DEB_LAST) begin
                            cnt         <= '0;
                            kp.key_held <= 1'b0;
                            col_idx     <= col_next;
                            kp.col_out  <= col_drive(col_next);
                            state       <= ST_SCAN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a keypad matrix model
module tb_keypad_scanner;
    import calc_pkg::*;

    localparam int S = 4;
    localparam int D = 8;

    localparam int M_SCAN = 0;
    localparam int M_DEB  = 1;
    localparam int M_PRS  = 2;
    localparam int M_REL  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic [15:0] pressed      = '0;
    logic        open_contact = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        kp.row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kp.col_out[c] && !open_contact)
                    kp.row_in[r] = 1'b0;
    end

    // Reference behaviour: plain integer bookkeeping of scan position and debounce runs.
    int         m_col   = 0;
    int         m_mode  = M_SCAN;
    int         m_dwell = 0;
    int         m_good  = 0;
    int         m_quiet = 0;
    int         m_row   = 0;
    logic [3:0] m_pat   = 4'hF;
    logic [3:0] m_s1    = 4'hF;
    logic [3:0] m_s2    = 4'hF;
    logic [3:0] m_raw   = 4'hF;
    logic [3:0] m_rs    = 4'hF;
    logic [3:0] m_code  = 4'd0;
    logic       m_valid = 1'b0;
    logic       m_held  = 1'b0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_col = 0; m_mode = M_SCAN; m_dwell = 0; m_good = 0; m_quiet = 0;
            m_pat = 4'hF; m_s1 = 4'hF; m_s2 = 4'hF;
            m_code = 4'd0; m_valid = 1'b0; m_held = 1'b0;
        end else begin
            m_raw = 4'hF;
            for (int r = 0; r < 4; r++)
                if (pressed[r*4+m_col] && !open_contact) m_raw[r] = 1'b0;
            m_rs = m_s2; m_s2 = m_s1; m_s1 = m_raw;
            m_valid = 1'b0;
            if (m_mode == M_SCAN) begin
                if (m_dwell == S - 1) begin
                    m_dwell = 0;
                    if (m_rs != 4'hF) begin m_pat = m_rs; m_good = 0; m_mode = M_DEB; end
                    else m_col = (m_col + 1) % 4;
                end else m_dwell++;
            end else if (m_mode == M_DEB) begin
                if (m_rs == m_pat) begin
                    m_good++;
                    if (m_good == D) m_mode = M_PRS;
                end else begin
                    m_dwell = 0; m_mode = M_SCAN;
                end
            end else if (m_mode == M_PRS) begin
                m_row = 0;
                for (int r = 3; r >= 0; r--) if (!m_pat[r]) m_row = r;
                m_code  = 4'(m_row * 4 + m_col);
                m_valid = 1'b1;
                m_held  = 1'b1;
                m_quiet = 0;
                m_mode  = M_REL;
            end else begin
                if (m_rs == 4'hF) begin
                    m_quiet++;
                    if (m_quiet == D) begin
                        m_held = 1'b0; m_col = (m_col + 1) % 4; m_dwell = 0; m_mode = M_SCAN;
                    end
                end else m_quiet = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of every output against the reference.
    logic [3:0] exp_col;
    initial forever begin
        @(negedge clk);
        exp_col = ~(4'b0001 << m_col);
        check("model_col_out",   kp.col_out,   exp_col);
        check("model_key_code",  kp.key_code,  m_code);
        check("model_key_valid", kp.key_valid, m_valid);
        check("model_key_held",  kp.key_held,  m_held);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (kp.key_valid === 1'b1) pulses++;
        end
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (kp.key_valid !== 1'b1 && n < limit) begin tick(1); n++; end
        check({name, "_valid_seen"}, 32'(kp.key_valid === 1'b1), 32'd1);
    endtask

    task automatic wait_held_low(input int limit, output int n);
        n = 0;
        while (kp.key_held !== 1'b0 && n < limit) begin tick(1); n++; end
    endtask

    int n_rel;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_col_out",   kp.col_out,   4'b1110);
        check("rst_key_code",  kp.key_code,  4'd0);
        check("rst_key_valid", kp.key_valid, 1'b0);
        check("rst_key_held",  kp.key_held,  1'b0);

        // 1: idle scan, each column held 4 cycles, wraps back to column 0
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] want;
            tick(1);
            want = ~(4'b0001 << (((i + 1) / 4) % 4));
            check("idle_col_seq", kp.col_out, want);
        end
        check("idle_no_pulse", pulses, 0);

        // 2: clean press row 1 / column 2
        pulses = 0;
        pressed[6] = 1'b1;
        wait_valid("clean", 200);
        check("clean_code", kp.key_code, KEY_6);
        check("clean_held", kp.key_held, 1'b1);
        tick(1);
        check("clean_one_cycle", kp.key_valid, 1'b0);
        tick(20);
        check("clean_pulses", pulses, 1);
        pressed = '0;
        wait_held_low(100, n_rel);
        check("clean_release_edges", n_rel, 2 + D);
        check("clean_next_col", kp.col_out, 4'b0111);
        tick(5);

        // 3: bouncing contact, then stable
        pulses = 0;
        pressed[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            open_contact = ((i / 3) % 2) == 1;
            tick(1);
        end
        check("bounce_no_pulse", pulses, 0);
        open_contact = 1'b0;
        wait_valid("bounce", 200);
        check("bounce_code", kp.key_code, KEY_1);
        tick(5);
        check("bounce_pulses", pulses, 1);
        pressed = '0;
        wait_held_low(100, n_rel);
        check("bounce_release", kp.key_held, 1'b0);
        tick(5);

        // 4: two rows in column 1, then extra keys during release
        pulses = 0;
        pressed[1]  = 1'b1;
        pressed[13] = 1'b1;
        wait_valid("multi", 200);
        check("multi_code", kp.key_code, KEY_2);
        pressed[9] = 1'b1;
        pressed[4] = 1'b1;
        tick(20);
        pressed[1]  = 1'b0;
        pressed[13] = 1'b0;
        tick(20);
        check("multi_still_held", kp.key_held, 1'b1);
        check("multi_pulses", pulses, 1);
        pressed = '0;
        wait_held_low(100, n_rel);
        check("multi_release_edges", n_rel, 2 + D);
        tick(5);
        check("multi_pulses_after", pulses, 1);

        // 5: reset asserted 4 cycles into debounce
        pulses = 0;
        pressed[5] = 1'b1;
        for (int i = 0; i < 200 && m_mode != M_DEB; i++) tick(1);
        check("rstdeb_entered", m_mode, M_DEB);
        tick(4);
        #2 reset = 1'b0;
        #1;
        check("rstdeb_col", kp.col_out, 4'b1110);
        check("rstdeb_valid", kp.key_valid, 1'b0);
        check("rstdeb_held", kp.key_held, 1'b0);
        pressed = '0;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("rstdeb_restart_col0", kp.col_out, 4'b1110);
        tick(3);
        check("rstdeb_restart_col1", kp.col_out, 4'b1101);
        tick(16);
        check("rstdeb_no_pulse", pulses, 0);

        // 6: column 3 key and wrap to column 0 after release
        pulses = 0;
        pressed[11] = 1'b1;
        wait_valid("col3", 200);
        check("col3_code", kp.key_code, KEY_C);
        tick(3);
        pressed = '0;
        wait_held_low(100, n_rel);
        check("col3_release_edges", n_rel, 2 + D);
        check("col3_wrap_col", kp.col_out, 4'b1110);
        tick(5);
        check("col3_pulses", pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
